// File: rtl/conv1_row_window_gen.sv
// Line buffer for conv1: holds a 5-row image band and emits 5-row x 8-pixel windows, 7 per output row, 28 rows.
// Latency: first window the cycle after the 20th word; then one window per cycle, 4-word reload between rows.
// Backpressure: window outputs hold while win_ready_i is low; no input is accepted while windows are emitted.
//
// Ports:
//   clk_i, rst_n_i               clock, asynchronous active-low reset
//   pxl_valid_i/pxl_ready_o      input word handshake; pxl_sof_i marks word 0 of row 0 of a frame
//   pxl_data_i                   8 pixels, pixel q at [8q+7:8q], q=0 leftmost
//   win_valid_o/win_ready_i      window handshake
//   intm_row_data_o              5 window rows, index 0 = top row
//   win_row_o, win_col_o         window position (r: 0..27, c: 0..6); win_last_o flags (27,6)
module conv1_row_window_gen #(
  parameter int PXL_WIDTH     = 8,
  parameter int DATA_WIDTH    = 64,
  parameter int NUM_FILT_ROWS = 5,
  parameter int FILT_INST     = 4,
  parameter int IMG_W         = 32,
  parameter int IMG_H         = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_n_i,
  input  logic                                     pxl_valid_i,
  output logic                                     pxl_ready_o,
  input  logic                                     pxl_sof_i,
  input  logic [DATA_WIDTH-1:0]                    pxl_data_i,
  output logic                                     win_valid_o,
  input  logic                                     win_ready_i,
  output logic [NUM_FILT_ROWS-1:0][DATA_WIDTH-1:0] intm_row_data_o,
  output logic [4:0]                               win_row_o,
  output logic [2:0]                               win_col_o,
  output logic                                     win_last_o
);

  localparam int NUM_PXL       = DATA_WIDTH / PXL_WIDTH;
  localparam int WORDS_PER_ROW = IMG_W / NUM_PXL;
  localparam int NUM_WIN       = (IMG_W - NUM_FILT_ROWS + 1) / FILT_INST;
  localparam int NUM_OUT_ROWS  = IMG_H - NUM_FILT_ROWS + 1;
  // Bits in half a word: the horizontal window stride.
  localparam int HALF          = FILT_INST * PXL_WIDTH;

  localparam logic [4:0] ROW_LAST  = 5'(NUM_OUT_ROWS - 1);
  localparam logic [2:0] COL_LAST  = 3'(NUM_WIN - 1);
  localparam logic [2:0] SLOT_LAST = 3'(NUM_FILT_ROWS - 1);
  localparam logic [1:0] WCNT_LAST = 2'(WORDS_PER_ROW - 1);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] top_q, top_d;     // ring slot holding the top (oldest) window row
  logic [2:0] frow_q, frow_d;   // row being written during FILL
  logic [1:0] wcnt_q, wcnt_d;   // word position within the row being written
  logic [4:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic       pxl_ready_q, pxl_ready_d;
  logic       win_valid_q, win_valid_d;
  logic       win_last_q, win_last_d;
  logic [NUM_FILT_ROWS-1:0][DATA_WIDTH-1:0] data_q, data_d, win_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_FILT_ROWS][WORDS_PER_ROW];
  logic [DATA_WIDTH-1:0] mem_d [NUM_FILT_ROWS][WORDS_PER_ROW];

  logic                  accept, win_hs;
  logic [3:0]            slot;
  logic [DATA_WIDTH-1:0] lo_word, hi_word;

  always_comb begin
    state_d = state_q;
    top_d   = top_q;
    frow_d  = frow_q;
    wcnt_d  = wcnt_q;
    row_d   = row_q;
    col_d   = col_q;
    mem_d   = mem_q;
    accept  = pxl_valid_i && pxl_ready_q;
    win_hs  = win_valid_q && win_ready_i;

    // accept can only fire in FILL/LOAD and win_hs only in EMIT, so these branches never overlap.
    if (accept && pxl_sof_i) begin
      // A start-of-frame word restarts everything, whatever we were doing.
      mem_d[0][0] = pxl_data_i;
      state_d     = ST_FILL;
      top_d       = '0;
      frow_d      = '0;
      wcnt_d      = 2'd1;
      row_d       = '0;
      col_d       = '0;
    end else if (accept && state_q == ST_FILL) begin
      mem_d[frow_q][wcnt_q] = pxl_data_i;
      wcnt_d = wcnt_q + 2'd1;
      if (wcnt_q == WCNT_LAST) begin
        wcnt_d = '0;
        if (frow_q == SLOT_LAST) begin
          frow_d  = '0;
          state_d = ST_EMIT;
          row_d   = '0;
          col_d   = '0;
        end else begin
          frow_d = frow_q + 3'd1;
        end
      end
    end else if (accept && state_q == ST_LOAD) begin
      // The new row overwrites the oldest slot, which then becomes the bottom row.
      mem_d[top_q][wcnt_q] = pxl_data_i;
      wcnt_d = wcnt_q + 2'd1;
      if (wcnt_q == WCNT_LAST) begin
        wcnt_d  = '0;
        top_d   = (top_q == SLOT_LAST) ? 3'd0 : top_q + 3'd1;
        row_d   = row_q + 5'd1;
        col_d   = '0;
        state_d = ST_EMIT;
      end
    end else if (win_hs) begin
      if (col_q == COL_LAST) begin
        if (row_q == ROW_LAST) begin
          state_d = ST_FILL;
          top_d   = '0;
          frow_d  = '0;
          wcnt_d  = '0;
          row_d   = '0;
          col_d   = '0;
        end else begin
          state_d = ST_LOAD;
        end
      end else begin
        col_d = col_q + 3'd1;
      end
    end

    // Window for the next (row, col), built from the ring including any word written this cycle.
    // Odd columns straddle two words: right half of word c/2 followed by left half of the next word.
    win_d   = '0;
    slot    = '0;
    lo_word = '0;
    hi_word = '0;
    for (int k = 0; k < NUM_FILT_ROWS; k++) begin
      slot = {1'b0, top_d} + 4'(k);
      if (slot >= 4'(NUM_FILT_ROWS)) begin
        slot = slot - 4'(NUM_FILT_ROWS);
      end
      lo_word = mem_d[slot[2:0]][col_d[2:1]];
      hi_word = mem_d[slot[2:0]][col_d[2:1] + 2'd1];
      win_d[k] = col_d[0] ? {hi_word[HALF-1:0], lo_word[DATA_WIDTH-1:HALF]} : lo_word;
    end

    // While stalled nothing feeding win_d changes, so reloading every EMIT cycle keeps the output stable.
    data_d      = (state_d == ST_EMIT) ? win_d : data_q;
    pxl_ready_d = (state_d != ST_EMIT);
    win_valid_d = (state_d == ST_EMIT);
    win_last_d  = (state_d == ST_EMIT) && (row_d == ROW_LAST) && (col_d == COL_LAST);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_FILL;
      top_q       <= '0;
      frow_q      <= '0;
      wcnt_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      pxl_ready_q <= 1'b0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      data_q      <= '0;
      for (int i = 0; i < NUM_FILT_ROWS; i++) begin
        for (int j = 0; j < WORDS_PER_ROW; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      top_q       <= top_d;
      frow_q      <= frow_d;
      wcnt_q      <= wcnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pxl_ready_q <= pxl_ready_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      data_q      <= data_d;
      mem_q       <= mem_d;
    end
  end

  assign pxl_ready_o     = pxl_ready_q;
  assign win_valid_o     = win_valid_q;
  assign intm_row_data_o = data_q;
  assign win_row_o       = row_q;
  assign win_col_o       = col_q;
  assign win_last_o      = win_last_q;

endmodule
